// File: rtl/decode_ctrl_pipe.sv
// RV32I decode-stage control with ID/EX control register and EX-stage branch resolution.
// Controls reach E one cycle after D; PCSrcE is combinational from E state; flush beats stall.
module decode_ctrl_pipe #(
  parameter int D_WIDTH     = 32,
  parameter int FULL_BRANCH = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   InstrD,
  input  logic                 ValidD,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic [2:0]           ImmSrcD,
  output logic                 RegWriteE,
  output logic [1:0]           ResultSrcE,
  output logic                 MemWriteE,
  output logic                 ALUSrcE,
  output logic                 ALUSrcAE,
  output logic [1:0]           ALUOpE,
  output logic                 JALRctrlE,
  output logic                 ValidE,
  output logic                 IllegalE,
  output logic                 PCSrcE,
  output logic [CNT_WIDTH-1:0] RedirCnt
);

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic       alu_src_a;
    logic [1:0] alu_op;
    logic       jalr;
    logic       valid;
    logic       illegal;
    logic       branch;
    logic       jump;
    logic [2:0] br_fn3;
  } ctrl_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [6:0]  w_opcode;
  logic [2:0]  w_fn3;
  logic        w_br_legal;
  logic [2:0]  w_imm_src;
  ctrl_t       w_dec;
  ctrl_t       r_e;
  logic        w_cond;
  logic        w_pcsrc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic        w_unused_bits;

  assign w_opcode      = InstrD[6:0];
  assign w_fn3         = InstrD[14:12];
  assign w_unused_bits = ^InstrD[D_WIDTH-1:15] ^ ^InstrD[11:7];

  // funct3 010/011 are never branches; the signed/unsigned compares need FULL_BRANCH.
  assign w_br_legal = (w_fn3[2:1] != 2'b01) && ((FULL_BRANCH != 0) || !w_fn3[2]);

  always_comb begin
    w_imm_src = 3'b000;
    w_dec     = '0;
    case (w_opcode)
      OP_R: begin
        w_imm_src       = 3'b111;
        w_dec.alu_op    = 2'b10;
        w_dec.reg_write = 1'b1;
      end
      OP_IALU: begin
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = 2'b10;
        w_dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 2'b01;
        w_dec.reg_write  = 1'b1;
      end
      OP_STORE: begin
        w_imm_src       = 3'b001;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
      end
      OP_B: begin
        if (w_br_legal) begin
          w_imm_src    = 3'b010;
          w_dec.alu_op = 2'b01;
          w_dec.branch = 1'b1;
          w_dec.br_fn3 = w_fn3;
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      OP_JAL: begin
        w_imm_src        = 3'b011;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
      end
      OP_JALR: begin
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
        w_dec.jalr       = 1'b1;
      end
      OP_LUI: begin
        w_imm_src       = 3'b100;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = 2'b11;
        w_dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        w_imm_src       = 3'b100;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_src_a = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase
    w_dec.valid = 1'b1;
  end

  always_comb begin
    w_cond = 1'b0;
    case (r_e.br_fn3)
      3'b000:  w_cond = ZeroE;
      3'b001:  w_cond = !ZeroE;
      3'b100:  w_cond = LtE;
      3'b101:  w_cond = !LtE;
      3'b110:  w_cond = LtuE;
      3'b111:  w_cond = !LtuE;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pcsrc = r_e.valid & (r_e.jump | (r_e.branch & w_cond));

  // The redirect flushes E itself, so a branch held by StallE cannot redirect twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
    end else if (w_pcsrc || FlushE) begin
      r_e <= '0;
    end else if (StallE) begin
      r_e <= r_e;
    end else if (!ValidD) begin
      r_e <= '0;
    end else begin
      r_e <= w_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_pcsrc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign ImmSrcD    = w_imm_src;
  assign RegWriteE  = r_e.reg_write;
  assign ResultSrcE = r_e.result_src;
  assign MemWriteE  = r_e.mem_write;
  assign ALUSrcE    = r_e.alu_src;
  assign ALUSrcAE   = r_e.alu_src_a;
  assign ALUOpE     = r_e.alu_op;
  assign JALRctrlE  = r_e.jalr;
  assign ValidE     = r_e.valid;
  assign IllegalE   = r_e.illegal;
  assign PCSrcE     = w_pcsrc;
  assign RedirCnt   = r_cnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomized scoreboard bench for decode_ctrl_pipe: a full-branch/16-bit-counter instance and a
// beq/bne-only/2-bit-counter instance share stimulus and are checked against a spec-level model.
module tb_decode_ctrl_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [31:0] InstrD = '0;
  logic        ValidD = 1'b0, StallE = 1'b0, FlushE = 1'b0;
  logic        ZeroE = 1'b0, LtE = 1'b0, LtuE = 1'b0;

  logic [2:0]  imm_a, imm_b;
  logic        rw_a, mw_a, as_a, asa_a, jalr_a, v_a, ill_a, pc_a;
  logic        rw_b, mw_b, as_b, asa_b, jalr_b, v_b, ill_b, pc_b;
  logic [1:0]  rs_a, op_a, rs_b, op_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  decode_ctrl_pipe #(.D_WIDTH(32), .FULL_BRANCH(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE),
    .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .ImmSrcD(imm_a),
    .RegWriteE(rw_a), .ResultSrcE(rs_a), .MemWriteE(mw_a), .ALUSrcE(as_a),
    .ALUSrcAE(asa_a), .ALUOpE(op_a), .JALRctrlE(jalr_a), .ValidE(v_a),
    .IllegalE(ill_a), .PCSrcE(pc_a), .RedirCnt(cnt_a));

  decode_ctrl_pipe #(.D_WIDTH(32), .FULL_BRANCH(0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE),
    .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .ImmSrcD(imm_b),
    .RegWriteE(rw_b), .ResultSrcE(rs_b), .MemWriteE(mw_b), .ALUSrcE(as_b),
    .ALUSrcAE(asa_b), .ALUOpE(op_b), .JALRctrlE(jalr_b), .ValidE(v_b),
    .IllegalE(ill_b), .PCSrcE(pc_b), .RedirCnt(cnt_b));

  // Model view of an instruction sitting in E.
  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw, as, asa;
    logic [1:0] op;
    logic       jalr, v, ill, br, jmp;
    logic [2:0] fn3;
  } e_t;

  typedef struct {
    logic [10:0] ctl;
    logic        pc;
    int          cnt;
    logic [2:0]  imm;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  e_t   m_e[2];
  int   m_cnt[2];
  int   n_chk = 0;
  int   n_fail = 0;

  // Instruction-class table: imm, ALUSrc, ALUSrcA, ALUOp, ResultSrc plus flags.
  function automatic e_t dec(input logic [31:0] ins, input bit fb, output logic [2:0] imm);
    e_t   d;
    int   f3;
    bit   bok;
    d   = '0;
    imm = 3'b000;
    f3  = int'(ins[14:12]);
    bok = (f3 == 0) || (f3 == 1) || (fb && f3 >= 4);
    d.v = 1'b1;
    case (ins[6:0])
      7'h33: begin imm = 3'd7; d.op = 2'd2; d.rw = 1; end
      7'h13: begin d.as = 1; d.op = 2'd2; d.rw = 1; end
      7'h03: begin d.as = 1; d.rs = 2'd1; d.rw = 1; end
      7'h23: begin imm = 3'd1; d.as = 1; d.mw = 1; end
      7'h63: if (bok) begin imm = 3'd2; d.op = 2'd1; d.br = 1; d.fn3 = ins[14:12]; end
             else d.ill = 1;
      7'h6F: begin imm = 3'd3; d.as = 1; d.rs = 2'd2; d.rw = 1; d.jmp = 1; end
      7'h67: begin d.as = 1; d.rs = 2'd2; d.rw = 1; d.jmp = 1; d.jalr = 1; end
      7'h37: begin imm = 3'd4; d.as = 1; d.op = 2'd3; d.rw = 1; end
      7'h17: begin imm = 3'd4; d.as = 1; d.asa = 1; d.rw = 1; end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  function automatic bit taken(input e_t e, input bit z, input bit lt, input bit ltu);
    if (!e.v) return 0;
    if (e.jmp) return 1;
    if (!e.br) return 0;
    case (int'(e.fn3))
      0: return z;
      1: return !z;
      4: return lt;
      5: return !lt;
      6: return ltu;
      7: return !ltu;
      default: return 0;
    endcase
  endfunction

  // One clock of stimulus: drive, push this cycle's expectation, advance the model.
  task automatic cyc(input logic [31:0] ins, input bit vd, input bit st, input bit fl,
                     input bit z, input bit lt, input bit ltu, input bit rn);
    e_t   d;
    exp_t x;
    bit   pc;
    int   cmax;
    @(posedge clk);
    #1;
    InstrD = ins; ValidD = vd; StallE = st; FlushE = fl;
    ZeroE = z; LtE = lt; LtuE = ltu; rst_n = rn;
    for (int i = 0; i < 2; i++) begin
      cmax = (i == 0) ? 65535 : 3;
      if (!rn) begin
        m_e[i]   = '0;
        m_cnt[i] = 0;
      end
      d     = dec(ins, i == 0, x.imm);
      pc    = taken(m_e[i], z, lt, ltu);
      x.ctl = {m_e[i].rw, m_e[i].rs, m_e[i].mw, m_e[i].as, m_e[i].asa, m_e[i].op,
               m_e[i].jalr, m_e[i].v, m_e[i].ill};
      x.pc  = pc;
      x.cnt = m_cnt[i];
      if (i == 0) q_a.push_back(x); else q_b.push_back(x);
      if (rn) begin
        if (pc && m_cnt[i] < cmax) m_cnt[i]++;
        if (pc || fl) m_e[i] = '0;
        else if (st) m_e[i] = m_e[i];
        else if (!vd) m_e[i] = '0;
        else m_e[i] = d;
      end
    end
  endtask

  task automatic chk(input string nm, input exp_t x, input logic [10:0] ctl, input logic pc,
                     input int cnt, input logic [2:0] imm);
    n_chk++;
    if (ctl !== x.ctl) begin
      n_fail++;
      $display("FAIL %s E-controls got=%b want=%b t=%0t", nm, ctl, x.ctl, $time);
    end
    n_chk++;
    if (pc !== x.pc) begin
      n_fail++;
      $display("FAIL %s PCSrcE got=%b want=%b t=%0t", nm, pc, x.pc, $time);
    end
    n_chk++;
    if (cnt != x.cnt) begin
      n_fail++;
      $display("FAIL %s RedirCnt got=%0d want=%0d t=%0t", nm, cnt, x.cnt, $time);
    end
    n_chk++;
    if (imm !== x.imm) begin
      n_fail++;
      $display("FAIL %s ImmSrcD got=%b want=%b t=%0t", nm, imm, x.imm, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q_a.size() > 0)
        chk("dutA", q_a.pop_front(), {rw_a, rs_a, mw_a, as_a, asa_a, op_a, jalr_a, v_a, ill_a},
            pc_a, int'(cnt_a), imm_a);
      if (q_b.size() > 0)
        chk("dutB", q_b.pop_front(), {rw_b, rs_b, mw_b, as_b, asa_b, op_b, jalr_b, v_b, ill_b},
            pc_b, int'(cnt_b), imm_b);
    end
  end

  function automatic logic [31:0] rnd_ins();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  function automatic logic [31:0] br_ins(input int f3);
    logic [31:0] r;
    r = 32'h0000_0063;
    r[14:12] = 3'(f3);
    return r;
  endfunction

  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  initial begin
    int wait_cyc;
    for (int i = 0; i < 2; i++) begin
      m_e[i] = '0;
      m_cnt[i] = 0;
    end
    // Reset held with random inputs.
    for (int i = 0; i < 5; i++)
      cyc($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'b0);
    // Load then add.
    cyc(32'h0000_C283, 1, 0, 0, 0, 0, 0, 1);
    cyc(32'h0053_03B3, 1, 0, 0, 0, 0, 0, 1);
    cyc(NOP, 0, 0, 0, 0, 0, 0, 1);
    // Branch sweep: every funct3 against every flag combination.
    for (int f = 0; f < 8; f++) begin
      for (int fl = 0; fl < 8; fl++) begin
        cyc(br_ins(f), 1, 0, 0, 0, 0, 0, 1);
        cyc(NOP, 0, 0, 0, fl[0], fl[1], fl[2], 1);
        cyc(NOP, 0, 0, 0, 0, 0, 0, 1);
      end
    end
    // Stall holds, flush beats stall.
    cyc(32'h0053_03B3, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(rnd_ins(), 1, 1, 0, 0, 0, 0, 1);
    cyc(NOP, 1, 1, 1, 0, 0, 0, 1);
    cyc(NOP, 0, 0, 0, 0, 0, 0, 1);
    // Taken JAL under stall fires once.
    cyc(JAL, 1, 0, 0, 0, 0, 0, 1);
    cyc(NOP, 1, 1, 0, 0, 0, 0, 1);
    cyc(NOP, 1, 1, 0, 0, 0, 0, 1);
    cyc(NOP, 0, 0, 0, 0, 0, 0, 1);
    // Illegal opcode, valid then bubble.
    cyc(32'h0000_007F, 1, 0, 0, 0, 0, 0, 1);
    cyc(32'h0000_007F, 0, 0, 0, 0, 0, 0, 1);
    cyc(NOP, 0, 0, 0, 0, 0, 0, 1);
    // Counter saturation on the narrow instance, then a reset pulse with a JAL in E.
    for (int i = 0; i < 5; i++) begin
      cyc(JAL, 1, 0, 0, 0, 0, 0, 1);
      cyc(NOP, 0, 0, 0, 0, 0, 0, 1);
    end
    cyc(JAL, 1, 0, 0, 0, 0, 0, 1);
    cyc(NOP, 0, 0, 0, 0, 0, 0, 0);
    cyc(NOP, 0, 0, 0, 0, 0, 0, 1);
    // Random traffic.
    for (int i = 0; i < 2000; i++)
      cyc(rnd_ins(), $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 149) != 0);
    wait_cyc = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    n_chk++;
    if (q_a.size() > 0 || q_b.size() > 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want=0", q_a.size() + q_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
